// File: rtl/uart_tx_sched_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM states, timer width
// and helpers that derive the transmitter bit and frame periods.
package uart_tx_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  localparam int TIMER_W = 16;
  localparam int IDX_W   = 3;

  // One transmitter bit period, matching the divider used by uart_transmit.
  function automatic int bit_cyc(input int clk_freq, input int bps);
    return clk_freq / bps + 1;
  endfunction

  // Start + 8 data + stop + transmitter tail = 11 bit periods, plus idle gap bits.
  function automatic int frame_cyc(input int clk_freq, input int bps, input int gap_bits);
    return (11 + gap_bits) * bit_cyc(clk_freq, bps);
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request searching upward from
// ptr+1 with wrap-around; returns one-hot grant, its index and a valid flag.
import uart_tx_sched_pkg::*;

module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  int idx;

  // Walk candidates from farthest to nearest so the nearest set request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    idx       = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (req[idx]) begin
        grant     = N_REQ'(1) << idx;
        grant_idx = IDX_W'(idx);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_transmit between N_REQ byte sources;
// captures and holds the granted byte for a full frame plus idle gap.
import uart_tx_sched_pkg::*;

module uart_tx_sched #(
  parameter int CLK_FREQ = 25000000,
  parameter int BPS_CONS = 115200,
  parameter int N_REQ    = 4,
  parameter int GAP_BITS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic [IDX_W-1:0]   grant_id,
  output logic               tx_en,
  output logic [7:0]         tx_data
);

  localparam int                 FRAME_CYC  = frame_cyc(CLK_FREQ, BPS_CONS, GAP_BITS);
  localparam logic [TIMER_W-1:0] FRAME_LAST = TIMER_W'(FRAME_CYC - 1);

  state_t             state;
  state_t             state_nxt;
  logic               grant_now;
  logic [IDX_W-1:0]   ptr;
  logic [TIMER_W-1:0] timer;
  logic [N_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_vld)
  );

  always_comb begin
    state_nxt = state;
    grant_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          state_nxt = ST_SEND;
          grant_now = 1'b1;
        end
      end
      ST_SEND: begin
        if (timer == '0) state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Pointer resets to the last requester so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack      <= '0;
      tx_en    <= 1'b0;
      busy     <= 1'b0;
      tx_data  <= 8'h00;
      grant_id <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
      timer    <= '0;
    end else begin
      ack   <= '0;
      tx_en <= 1'b0;
      if (grant_now) begin
        tx_data  <= req_data[{arb_idx, 3'b000} +: 8];
        ack      <= arb_grant;
        tx_en    <= 1'b1;
        busy     <= 1'b1;
        grant_id <= arb_idx;
        ptr      <= arb_idx;
        timer    <= FRAME_LAST;
      end else if (state == ST_SEND) begin
        if (timer == '0) busy  <= 1'b0;
        else             timer <= timer - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: expected grants are queued when requests
// are raised and compared when ack/tx_en appear; holds and timing are checked per cycle.
module tb_uart_tx_sched;

  localparam int N_REQ     = 4;
  localparam int FRAME_CYC = 2616;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N_REQ-1:0]   req = '0;
  logic [8*N_REQ-1:0] req_data = '0;
  logic [N_REQ-1:0]   ack;
  logic               busy;
  logic [2:0]         grant_id;
  logic               tx_en;
  logic [7:0]         tx_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  uart_tx_sched #(
    .CLK_FREQ (25000000),
    .BPS_CONS (115200),
    .N_REQ    (N_REQ),
    .GAP_BITS (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_data (req_data),
    .ack      (ack),
    .busy     (busy),
    .grant_id (grant_id),
    .tx_en    (tx_en),
    .tx_data  (tx_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push(input int id, input logic [7:0] d);
    sb.push_back('{id: id, data: d});
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},      32'(ack),      32'(0));
    chk({tag, "_tx_en"},    32'(tx_en),    32'(0));
    chk({tag, "_busy"},     32'(busy),     32'(0));
    chk({tag, "_tx_data"},  32'(tx_data),  32'(0));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
  endtask

  // Wait for the next grant, compare it with the queue head, then follow the frame.
  task automatic serve(input logic [N_REQ-1:0] keep, input int exp_wait, input bit scramble,
                       input logic [N_REQ-1:0] late_mask, input int late_at, input int stop_at);
    int         waits;
    int         cyc;
    exp_t       e;
    logic [7:0] held;
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (ack == '0 && waits < 4 * FRAME_CYC);
    if (ack == '0) begin
      chk("ack_seen", 32'(ack != '0), 32'(1));
      return;
    end
    if (sb.size() == 0) begin
      chk("unexpected_grant", 32'(ack), 32'(0));
      return;
    end
    e = sb.pop_front();
    chk("grant_latency", 32'(waits),    32'(exp_wait));
    chk("ack_onehot",    32'(ack),      32'(1) << e.id);
    chk("tx_en_pulse",   32'(tx_en),    32'(1));
    chk("busy_rise",     32'(busy),     32'(1));
    chk("grant_id",      32'(grant_id), 32'(e.id));
    chk("tx_data",       32'(tx_data),  32'(e.data));
    req  = req & ~(ack & ~keep);
    held = e.data;
    cyc  = 1;
    forever begin
      if (stop_at != 0 && cyc >= stop_at) break;
      if (scramble) req_data[15:8] = 8'($urandom);
      if (late_at != 0 && cyc == late_at) req = req | late_mask;
      @(negedge clk);
      if (!busy || cyc > 2 * FRAME_CYC) break;
      cyc++;
      chk("tx_data_hold", 32'(tx_data), 32'(held));
      chk("ack_quiet",    32'(ack),     32'(0));
      chk("tx_en_quiet",  32'(tx_en),   32'(0));
    end
    if (stop_at == 0) chk("busy_length", 32'(cyc), 32'(FRAME_CYC));
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("idle");

    // Single request from requester 2
    req_data[23:16] = 8'hA5;
    push(2, 8'hA5);
    req = 4'b0100;
    serve('0, 1, 1'b0, '0, 0, 0);

    // All four from reset: rotation 0,1,2,3
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset2");
    rst = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    req = 4'b1111;
    for (int i = 0; i < 4; i++) serve('0, 1, 1'b0, '0, 0, 0);

    // Fairness: 0 and 3 held continuously alternate
    req_data = {8'hD3, 8'h00, 8'h00, 8'hD0};
    push(0, 8'hD0); push(3, 8'hD3); push(0, 8'hD0); push(3, 8'hD3);
    req = 4'b1001;
    for (int i = 0; i < 4; i++) serve(4'b1001, 1, 1'b0, '0, 0, 0);
    req = '0;

    // Hold: requester 1 data scrambled every cycle after capture
    req_data[15:8] = 8'h6C;
    push(1, 8'h6C);
    req = 4'b0010;
    serve('0, 1, 1'b1, '0, 0, 0);

    // Late request from requester 1 during a frame for requester 0
    req_data[7:0]  = 8'h77;
    req_data[15:8] = 8'h5A;
    push(0, 8'h77); push(1, 8'h5A);
    req = 4'b0001;
    serve('0, 1, 1'b0, 4'b0010, 500, 0);
    serve('0, 1, 1'b0, '0, 0, 0);

    // Reset mid-frame, then requester 0 wins first
    req_data[23:16] = 8'hC3;
    push(2, 8'hC3);
    req = 4'b0100;
    serve('0, 1, 1'b0, '0, 0, 1000);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midframe");
    req_data[7:0] = 8'hE1;
    req = 4'b0101;
    @(negedge clk);
    rst = 1'b1;
    push(0, 8'hE1);
    serve('0, 1, 1'b0, '0, 0, 0);
    req = '0;
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
